// File: rtl/io_uart_fifo.sv
// Memory-mapped 8N1 UART with TX/RX byte FIFOs, programmable divisor and level irq.
// Reads return one cycle after the strobe; a full FIFO drops the byte and raises a sticky flag.

module io_uart_sfifo #(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          push_i,
   input  logic [7:0]    push_dat_i,
   input  logic          pop_i,
   output logic [7:0]    head_dat_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o,
   output logic          ovf_o
);
   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [CW-1:0] cnt_q;
   logic          do_push, do_pop;

   assign empty_o    = (cnt_q == '0);
   assign full_o     = (cnt_q == CW'(DEPTH));
   assign do_pop     = pop_i & !empty_o;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_push    = push_i & (!full_o | pop_i);
   assign ovf_o      = push_i & full_o & !pop_i;
   assign head_dat_o = mem_q[rp_q];
   assign count_o    = cnt_q;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wp_q] <= push_dat_i;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wp_q <= wp_q + AW'(1);
         if (do_pop)  rp_q <= rp_q + AW'(1);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

module io_uart_fifo #(
   parameter int CLK_FREQ_HZ = 100000000,
   parameter int BAUD_RATE   = 115200,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        sel,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  wmask,
   input  logic        rd_en,
   output logic [31:0] rdata,
   input  logic        RXD,
   output logic        TXD,
   output logic        irq
);
   localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] DIV_RST = 16'(CLK_FREQ_HZ / BAUD_RATE);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

   logic wr, rd, data_wr, status_wr, baud_wr, ctrl_wr, rx_pop;
   assign wr        = sel & (|wmask);
   assign rd        = sel & rd_en;
   assign data_wr   = wr & (addr == 2'd0);
   assign status_wr = wr & (addr == 2'd1);
   assign baud_wr   = wr & (addr == 2'd2);
   assign ctrl_wr   = wr & (addr == 2'd3);
   assign rx_pop    = rd & (addr == 2'd0);

   logic [15:0] wdata_unused;
   assign wdata_unused = wdata[31:16];

   logic [15:0] div_q;
   logic        rx_ie_q, tx_ie_q, rx_ovr_q, frame_err_q, tx_ovf_q, irq_q;
   logic        rx_ovr_d, frame_err_d, tx_ovf_d, irq_d;
   logic [31:0] rdata_q, rd_mux, status_w;

   // FIFOs
   logic          tx_pop, tx_full, tx_empty, tx_fifo_ovf;
   logic [7:0]    tx_head;
   logic [CW-1:0] tx_count_unused;
   logic          rx_push, rx_full, rx_empty, rx_fifo_ovf;
   logic [7:0]    rx_head;
   logic [CW-1:0] rx_count;

   io_uart_sfifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .resetn(resetn), .push_i(data_wr), .push_dat_i(wdata[7:0]), .pop_i(tx_pop),
      .head_dat_o(tx_head), .count_o(tx_count_unused), .full_o(tx_full), .empty_o(tx_empty),
      .ovf_o(tx_fifo_ovf));

   logic [7:0] rx_sh_q, rx_sh_d;

   io_uart_sfifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .resetn(resetn), .push_i(rx_push), .push_dat_i(rx_sh_q), .pop_i(rx_pop),
      .head_dat_o(rx_head), .count_o(rx_count), .full_o(rx_full), .empty_o(rx_empty),
      .ovf_o(rx_fifo_ovf));

   // TX state machine
   tx_state_t   tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_sh_q, tx_sh_d;
   logic        txd_q, txd_d, tx_end, tx_busy;

   assign tx_end  = (tx_cnt_q == tx_div_q - 16'd1);
   assign tx_busy = (tx_state_q != TX_IDLE);

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      tx_div_d   = tx_div_q;
      tx_pop     = 1'b0;
      txd_d      = 1'b1;
      case (tx_state_q)
         TX_IDLE: if (!tx_empty) begin
            tx_pop = 1'b1; tx_sh_d = tx_head; tx_div_d = div_q; tx_cnt_d = '0; tx_state_d = TX_START;
         end
         TX_START: if (tx_end) begin
            tx_cnt_d = '0; tx_bit_d = '0; tx_state_d = TX_DATA;
         end else tx_cnt_d = tx_cnt_q + 16'd1;
         TX_DATA: if (tx_end) begin
            tx_cnt_d = '0; tx_sh_d = {1'b0, tx_sh_q[7:1]}; tx_bit_d = tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
         end else tx_cnt_d = tx_cnt_q + 16'd1;
         TX_STOP: if (tx_end) begin
            tx_cnt_d = '0;
            // Back-to-back frames: the next start bit follows the stop bit with no idle gap.
            if (!tx_empty) begin
               tx_pop = 1'b1; tx_sh_d = tx_head; tx_div_d = div_q; tx_state_d = TX_START;
            end else tx_state_d = TX_IDLE;
         end else tx_cnt_d = tx_cnt_q + 16'd1;
         default: tx_state_d = TX_IDLE;
      endcase
      case (tx_state_d)
         TX_START: txd_d = 1'b0;
         TX_DATA:  txd_d = tx_sh_d[0];
         default:  txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
         tx_div_q   <= DIV_RST;
         txd_q      <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
         tx_div_q   <= tx_div_d;
         txd_q      <= txd_d;
      end
   end

   // RX state machine
   rx_state_t   rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_half;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic        sync1_q, sync2_q, rxs_prev_q, rx_end, frame_set;

   assign rx_end  = (rx_cnt_q == rx_div_q - 16'd1);
   assign rx_half = {1'b0, rx_div_q[15:1]};

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_div_d   = rx_div_q;
      rx_push    = 1'b0;
      frame_set  = 1'b0;
      case (rx_state_q)
         RX_IDLE: if (rxs_prev_q && !sync2_q) begin
            rx_div_d = div_q; rx_cnt_d = '0; rx_state_d = RX_START;
         end
         RX_START: if (rx_cnt_q == rx_half - 16'd1) begin
            rx_cnt_d = '0; rx_bit_d = '0;
            rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
         end else rx_cnt_d = rx_cnt_q + 16'd1;
         RX_DATA: if (rx_end) begin
            rx_cnt_d = '0; rx_sh_d = {sync2_q, rx_sh_q[7:1]}; rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
         end else rx_cnt_d = rx_cnt_q + 16'd1;
         RX_STOP: if (rx_end) begin
            rx_cnt_d = '0;
            if (sync2_q) begin
               rx_push = 1'b1; rx_state_d = RX_IDLE;
            end else begin
               frame_set = 1'b1; rx_state_d = RX_WAIT_HIGH;
            end
         end else rx_cnt_d = rx_cnt_q + 16'd1;
         RX_WAIT_HIGH: if (sync2_q) rx_state_d = RX_IDLE;
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_div_q   <= DIV_RST;
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         rxs_prev_q <= 1'b1;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         rx_div_q   <= rx_div_d;
         sync1_q    <= RXD;
         sync2_q    <= sync1_q;
         rxs_prev_q <= sync2_q;
      end
   end

   // Sticky flags: a set event in the same cycle outranks the W1C clear.
   always_comb begin
      rx_ovr_d    = rx_fifo_ovf | (rx_ovr_q    & !(status_wr & wdata[5]));
      frame_err_d = frame_set   | (frame_err_q & !(status_wr & wdata[6]));
      tx_ovf_d    = tx_fifo_ovf | (tx_ovf_q    & !(status_wr & wdata[7]));
      irq_d       = (rx_ie_q & !rx_empty) | (tx_ie_q & tx_empty & !tx_busy);
      status_w    = {15'd0, 9'(rx_count), tx_ovf_q, frame_err_q, rx_ovr_q, rx_full, rx_empty,
                     tx_busy, tx_empty, tx_full};
      rd_mux      = '0;
      case (addr)
         2'd0:    rd_mux = rx_empty ? 32'd0 : {1'b1, 23'd0, rx_head};
         2'd1:    rd_mux = status_w;
         2'd2:    rd_mux = {16'd0, div_q};
         default: rd_mux = {30'd0, tx_ie_q, rx_ie_q};
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_q       <= DIV_RST;
         rx_ie_q     <= 1'b0;
         tx_ie_q     <= 1'b0;
         rx_ovr_q    <= 1'b0;
         frame_err_q <= 1'b0;
         tx_ovf_q    <= 1'b0;
         irq_q       <= 1'b0;
         rdata_q     <= '0;
      end else begin
         if (baud_wr && (wdata[15:0] >= 16'd4)) div_q <= wdata[15:0];
         if (ctrl_wr) begin
            rx_ie_q <= wdata[0];
            tx_ie_q <= wdata[1];
         end
         rx_ovr_q    <= rx_ovr_d;
         frame_err_q <= frame_err_d;
         tx_ovf_q    <= tx_ovf_d;
         irq_q       <= irq_d;
         rdata_q     <= rd ? rd_mux : 32'd0;
      end
   end

   assign rdata = rdata_q;
   assign TXD   = txd_q;
   assign irq   = irq_q;
endmodule

// File: tb/tb_io_uart_fifo.sv
// Directed bench for io_uart_fifo: register vector table plus serial TX/RX sequences at 16 clocks per bit.
`timescale 1ns/1ps
module tb_io_uart_fifo;
   logic        clk = 1'b0, resetn = 1'b0, sel = 1'b0, rd_en = 1'b0, RXD = 1'b1;
   logic [1:0]  addr = 2'd0;
   logic [31:0] wdata = 32'd0;
   logic [3:0]  wmask = 4'd0;
   logic [31:0] rdata;
   logic        TXD, irq;
   int          n_cmp = 0, n_bad = 0;

   io_uart_fifo #(.CLK_FREQ_HZ(1600000), .BAUD_RATE(100000), .FIFO_DEPTH(8)) dut (
      .clk(clk), .resetn(resetn), .sel(sel), .addr(addr), .wdata(wdata), .wmask(wmask),
      .rd_en(rd_en), .rdata(rdata), .RXD(RXD), .TXD(TXD), .irq(irq));

   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      logic [1:0]  a;
      logic [31:0] d;
      logic [31:0] exp;
      bit          exp_irq;
   } vec_t;
   vec_t tbl[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk); sel = 1'b1; rd_en = 1'b1; addr = a;
      @(negedge clk); d = rdata; sel = 1'b0; rd_en = 1'b0;
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk); sel = 1'b1; wmask = 4'hF; addr = a; wdata = d;
      @(negedge clk); sel = 1'b0; wmask = 4'h0;
   endtask

   // Drives one 16-clock-per-bit frame; optionally issues a DATA read at cycle rd_at of the frame.
   task automatic send_frame(input logic [7:0] b, input logic stop_b, input bit hold_low,
                             input int rd_at, output logic [31:0] rd_val);
      logic [9:0] fr;
      fr = {stop_b, b, 1'b0};
      rd_val = 32'd0;
      for (int c = 0; c < 160; c++) begin
         @(negedge clk);
         RXD = fr[c / 16];
         if (c == rd_at + 1) begin rd_val = rdata; sel = 1'b0; rd_en = 1'b0; end
         if (c == rd_at) begin sel = 1'b1; rd_en = 1'b1; addr = 2'd0; end
      end
      @(negedge clk);
      RXD = hold_low ? 1'b0 : 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      logic [8:0]  pat;
      logic [7:0]  b;
      int          lowc;

      tbl[0]  = '{1'b0, 2'd1, 32'h0,     32'h0A,   1'b0};
      tbl[1]  = '{1'b0, 2'd0, 32'h0,     32'h0,    1'b0};
      tbl[2]  = '{1'b0, 2'd2, 32'h0,     32'h10,   1'b0};
      tbl[3]  = '{1'b0, 2'd3, 32'h0,     32'h0,    1'b0};
      tbl[4]  = '{1'b1, 2'd3, 32'h2,     32'h0,    1'b1};
      tbl[5]  = '{1'b0, 2'd3, 32'h0,     32'h2,    1'b1};
      tbl[6]  = '{1'b1, 2'd3, 32'h1,     32'h0,    1'b0};
      tbl[7]  = '{1'b1, 2'd2, 32'h3,     32'h0,    1'b0};
      tbl[8]  = '{1'b0, 2'd2, 32'h0,     32'h10,   1'b0};
      tbl[9]  = '{1'b1, 2'd2, 32'h12345, 32'h0,    1'b0};
      tbl[10] = '{1'b0, 2'd2, 32'h0,     32'h2345, 1'b0};
      tbl[11] = '{1'b1, 2'd2, 32'h10,    32'h0,    1'b0};
      tbl[12] = '{1'b0, 2'd2, 32'h0,     32'h10,   1'b0};
      tbl[13] = '{1'b1, 2'd1, 32'hFF,    32'h0,    1'b0};
      tbl[14] = '{1'b0, 2'd1, 32'h0,     32'h0A,   1'b0};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_txd", 32'(TXD), 32'd1);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      // Register vectors
      for (int i = 0; i < 15; i++) begin
         if (tbl[i].wr) bus_wr(tbl[i].a, tbl[i].d);
         else begin
            bus_rd(tbl[i].a, r);
            check($sformatf("vec%0d_rdata", i), r, tbl[i].exp);
         end
         @(negedge clk);
         check($sformatf("vec%0d_irq", i), 32'(irq), 32'(tbl[i].exp_irq));
      end

      // TX frame of 0xA5
      bus_wr(2'd0, 32'hA5);
      lowc = 0;
      while (TXD !== 1'b0 && lowc < 50) begin @(negedge clk); lowc++; end
      check("tx_start_seen", 32'(TXD), 32'd0);
      lowc = 0;
      while (TXD === 1'b0 && lowc < 40) begin lowc++; @(negedge clk); end
      check("tx_start_len", lowc, 32'd16);
      repeat (7) @(negedge clk);
      pat = {1'b1, 8'hA5};
      for (int k = 0; k < 9; k++) begin
         check($sformatf("tx_bit%0d", k), 32'(TXD), 32'(pat[k]));
         bus_rd(2'd1, r);
         check($sformatf("tx_busy%0d", k), 32'(r[2]), 32'd1);
         repeat (14) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      bus_rd(2'd1, r);
      check("tx_done_status", r, 32'h0A);

      // RX of 0x3C with rx_ie set
      send_frame(8'h3C, 1'b1, 1'b0, -1, r);
      repeat (3) @(negedge clk);
      bus_rd(2'd1, r);
      check("rx_status_cnt1", r, 32'h102);
      check("rx_irq_set", 32'(irq), 32'd1);
      bus_rd(2'd0, r);
      check("rx_data", r, 32'h8000003C);
      @(negedge clk);
      check("rdata_idle_zero", rdata, 32'd0);
      check("rx_irq_clear", 32'(irq), 32'd0);
      bus_rd(2'd1, r);
      check("rx_status_empty", r, 32'h0A);

      // Framing error with RXD held low afterwards
      send_frame(8'h55, 1'b0, 1'b1, -1, r);
      repeat (30) @(negedge clk);
      bus_rd(2'd1, r);
      check("ferr_status", r, 32'h4A);
      RXD = 1'b1;
      repeat (5) @(negedge clk);
      bus_wr(2'd1, 32'h40);
      bus_rd(2'd1, r);
      check("ferr_cleared", r, 32'h0A);

      // Short low glitch
      @(negedge clk); RXD = 1'b0;
      repeat (3) @(negedge clk); RXD = 1'b1;
      repeat (40) @(negedge clk);
      bus_rd(2'd1, r);
      check("glitch_status", r, 32'h0A);

      // RX overrun
      for (int i = 0; i < 8; i++) begin
         b = 8'hA0 + 8'(i);
         send_frame(b, 1'b1, 1'b0, -1, r);
      end
      bus_rd(2'd1, r);
      check("rx_full_status", r, 32'h812);
      send_frame(8'h5A, 1'b1, 1'b0, -1, r);
      bus_rd(2'd1, r);
      check("rx_ovr_status", r, 32'h832);
      for (int i = 0; i < 8; i++) begin
         bus_rd(2'd0, r);
         check($sformatf("ovr_pop%0d", i), r, 32'h800000A0 + i);
      end
      bus_wr(2'd1, 32'h20);
      bus_rd(2'd1, r);
      check("rx_ovr_cleared", r, 32'h0A);

      // Pop coinciding with the push into a full RX FIFO
      for (int i = 0; i < 8; i++) begin
         b = 8'hC0 + 8'(i);
         send_frame(b, 1'b1, 1'b0, -1, r);
      end
      send_frame(8'h99, 1'b1, 1'b0, 154, r);
      check("same_cycle_pop", r, 32'h800000C0);
      bus_rd(2'd1, r);
      check("same_cycle_status", r, 32'h812);
      for (int i = 1; i < 9; i++) begin
         bus_rd(2'd0, r);
         check($sformatf("same_pop%0d", i), r, (i == 8) ? 32'h80000099 : 32'h800000C0 + i);
      end

      // TX FIFO fill, overflow, W1C, then reset mid-frame
      for (int i = 0; i < 9; i++) begin
         @(negedge clk); sel = 1'b1; wmask = 4'hF; addr = 2'd0; wdata = 32'h30 + i;
      end
      @(negedge clk); sel = 1'b0; wmask = 4'h0;
      bus_rd(2'd1, r);
      check("tx_full_status", r, 32'h0D);
      bus_wr(2'd0, 32'h77);
      bus_rd(2'd1, r);
      check("tx_ovf_status", r, 32'h8D);
      bus_wr(2'd1, 32'h80);
      bus_rd(2'd1, r);
      check("tx_ovf_cleared", r, 32'h0D);
      @(negedge clk);
      check("tx_midframe_low", 32'(TXD), 32'd0);
      resetn = 1'b0;
      #1;
      check("rst_mid_txd", 32'(TXD), 32'd1);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      bus_rd(2'd1, r);
      check("rst_mid_status", r, 32'h0A);
      bus_rd(2'd2, r);
      check("rst_mid_baud", r, 32'h10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
